tetris_playfield_ctrl: RTL

// Parametrised playfield engine for the tetris datapath: owns the settled-block background, the active piece
// (type, rotation, x, y), collision checking, merge, multi-line clear with row collapse, and game-over detect.

---
 rtl/tetris_playfield_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tetris_playfield_ctrl.sv
// tetris_playfield_ctrl: COLS x ROWS playfield engine with active piece, collision, merge, line clear and game over
// Inputs: clk_field, rst (sync, active high), start, tick, left, right, rotate, drop pulses, random[2:0] piece select.
// Outputs: field_display (background | piece, bit r*COLS+c, row 0 top), score_flag, lines_total, gameover, busy.
module tetris_playfield_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 40,
  parameter int CNT_W = 16
) (
  input  logic                   clk_field,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   tick,
  input  logic                   left,
  input  logic                   right,
  input  logic                   rotate,
  input  logic                   drop,
  input  logic [2:0]             random,
  output logic [COLS*ROWS-1:0]   field_display,
  output logic                   score_flag,
  output logic [CNT_W-1:0]       lines_total,
  output logic                   gameover,
  output logic                   busy
);
  localparam int XW = $clog2(COLS) + 2;
  localparam int YW = $clog2(ROWS + 1);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic signed [XW-1:0] SPAWN_X = XW'((COLS - 4) / 2);
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;
  typedef enum logic [2:0] {IDLE, SPAWN, PLAY, DROP, MERGE, CLEAR, OVER} state_t;
  state_t st, st_n;
  grid_t bg, bg_n, sh;
  logic [2:0] typ, typ_n, spawn_t;
  logic [1:0] rot, rot_n;
  logic signed [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [RW-1:0] row, row_n;
  logic act, act_n, got, got_n, flag_n;
  logic [CNT_W-1:0] lines_n;
  // 4x4 masks, bit r*4+c; I uses two orientations, O one
  function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] r);
    case (t)
      3'd1: shape = 16'h0066;
      3'd2: shape = r == 2'd0 ? 16'h0027 : r == 2'd1 ? 16'h0262 : r == 2'd2 ? 16'h0072 : 16'h0232;
      3'd3: shape = r[0] ? 16'h0231 : 16'h0036;
      3'd4: shape = r[0] ? 16'h0132 : 16'h0063;
      3'd5: shape = r == 2'd0 ? 16'h0071 : r == 2'd1 ? 16'h0226 : r == 2'd2 ? 16'h0470 : 16'h0322;
      3'd6: shape = r == 2'd0 ? 16'h0074 : r == 2'd1 ? 16'h0622 : r == 2'd2 ? 16'h0170 : 16'h0223;
      default: shape = r[0] ? 16'h4444 : 16'h000F;
    endcase
  endfunction
  function automatic logic hit(input logic signed [XW-1:0] px, input logic [YW-1:0] py,
                               input logic [15:0] m, input grid_t b);
    int c, rr;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c = int'(px) + i % 4;
      rr = int'(py) + i / 4;
      if (m[i]) begin
        if (c < 0 || c >= COLS || rr >= ROWS) hit = 1'b1;
        else if (b[RW'(rr)][CW'(c)]) hit = 1'b1;
      end
    end
  endfunction
  function automatic grid_t paint(input logic signed [XW-1:0] px, input logic [YW-1:0] py,
                                  input logic [15:0] m);
    int c, rr;
    paint = '0;
    for (int i = 0; i < 16; i++) begin
      c = int'(px) + i % 4;
      rr = int'(py) + i / 4;
      if (m[i] && c >= 0 && c < COLS && rr < ROWS) paint[RW'(rr)][CW'(c)] = 1'b1;
    end
  endfunction
  assign spawn_t = random == 3'd7 ? 3'd0 : random;
  assign gameover = st == OVER;
  assign busy = st inside {SPAWN, DROP, MERGE, CLEAR};
  // collapse rows 0..row down by one, top row emptied
  always_comb begin
    sh = bg;
    sh[0] = '0;
    for (int k = 1; k < ROWS; k++) if (k <= int'(row)) sh[k] = bg[k-1];
  end
  always_comb begin
    st_n = st;
    bg_n = bg;
    typ_n = typ;
    rot_n = rot;
    x_n = x;
    y_n = y;
    act_n = act;
    row_n = row;
    got_n = got;
    lines_n = lines_total;
    flag_n = 1'b0;
    case (st)
      IDLE, OVER: if (start) begin
        st_n = SPAWN;
        bg_n = '0;
        lines_n = '0;
      end
      SPAWN: begin
        typ_n = spawn_t;
        rot_n = 2'd0;
        x_n = SPAWN_X;
        y_n = '0;
        act_n = !hit(SPAWN_X, '0, shape(spawn_t, 2'd0), bg);
        st_n = act_n ? PLAY : OVER;
      end
      PLAY: begin
        if (drop) st_n = DROP;
        else if (rotate) rot_n = hit(x, y, shape(typ, rot + 2'd1), bg) ? rot : rot + 2'd1;
        else if (left) x_n = hit(x - 1'b1, y, shape(typ, rot), bg) ? x : x - 1'b1;
        else if (right) x_n = hit(x + 1'b1, y, shape(typ, rot), bg) ? x : x + 1'b1;
        else if (tick) begin
          if (hit(x, y + 1'b1, shape(typ, rot), bg)) st_n = MERGE;
          else y_n = y + 1'b1;
        end
      end
      DROP: begin
        if (hit(x, y + 1'b1, shape(typ, rot), bg)) st_n = MERGE;
        else y_n = y + 1'b1;
      end
      MERGE: begin
        bg_n = bg | paint(x, y, shape(typ, rot));
        act_n = 1'b0;
        row_n = RW'(ROWS - 1);
        got_n = 1'b0;
        st_n = CLEAR;
      end
      CLEAR: begin
        // a cleared row is rechecked since the row above has dropped into it
        if (&bg[row]) begin
          bg_n = sh;
          lines_n = &lines_total ? lines_total : lines_total + 1'b1;
          got_n = 1'b1;
        end else if (row == '0) begin
          st_n = SPAWN;
          flag_n = got;
        end else row_n = row - 1'b1;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_field) begin
    if (rst) begin
      st <= IDLE;
      bg <= '0;
      typ <= '0;
      rot <= '0;
      x <= '0;
      y <= '0;
      act <= 1'b0;
      row <= '0;
      got <= 1'b0;
      lines_total <= '0;
      score_flag <= 1'b0;
      field_display <= '0;
    end else begin
      st <= st_n;
      bg <= bg_n;
      typ <= typ_n;
      rot <= rot_n;
      x <= x_n;
      y <= y_n;
      act <= act_n;
      row <= row_n;
      got <= got_n;
      lines_total <= lines_n;
      score_flag <= flag_n;
      field_display <= bg | (act ? paint(x, y, shape(typ, rot)) : '0);
    end
  end
endmodule
